// File: rtl/sv_pkg.sv
// Shared types for the support-vector store: opcodes, pass FSM states and the
// fixed 2-bit signed label type.
package sv_pkg;

    typedef enum logic [1:0] {
        OP_TRAIN    = 2'b00,
        OP_CLASSIFY = 2'b01,
        OP_CLEAR    = 2'b10,
        OP_HOLD     = 2'b11
    } opcode_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam int Y_W = 2;

    // Labels are only ever +1 (01) or -1 (11); no arithmetic is done on them.
    typedef logic signed [Y_W-1:0] y_t;

endpackage

// File: rtl/sv_entry_ram.sv
// Entry storage for the support-vector store: one write port, one
// combinational read port, contents deliberately not reset.
module sv_entry_ram #(
    parameter  int DEPTH = 50,
    parameter  int W     = 20,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sv_store.sv
// Support-vector store: compacts accepted support vectors in TRAIN mode and
// replays them as a valid/ready stream on each CLASSIFY pass request.
//   state     | meaning
//   ST_IDLE   | no pass active; rd_valid low
//   ST_STREAM | pass active; output register walks entries 0..count-1
module sv_store
    import sv_pkg::*;
#(
    parameter  int X_W     = 9,
    parameter  int ALPHA_W = 9,
    parameter  int DEPTH   = 50,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         opcode,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic               wr_is_sv,
    input  logic [X_W-1:0]     wr_x,
    input  logic signed [1:0]  wr_y,
    input  logic [ALPHA_W-1:0] wr_alpha,
    input  logic               rd_start,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [X_W-1:0]     rd_x,
    output logic signed [1:0]  rd_y,
    output logic [ALPHA_W-1:0] rd_alpha,
    output logic               rd_last,
    output logic               busy,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [X_W-1:0]     x;
        y_t                 y;
        logic [ALPHA_W-1:0] alpha;
    } entry_t;

    opcode_t          op;
    state_t           state;
    logic [CNT_W-1:0] idx;
    entry_t           wr_entry;
    entry_t           rd_entry;
    logic             wr_fire;
    logic             store;

    assign op       = opcode_t'(opcode);
    assign full     = (count == CNT_W'(DEPTH));
    assign wr_ready = (op == OP_TRAIN) && !busy && !reset;
    assign wr_fire  = wr_valid && wr_ready;
    assign store    = wr_fire && wr_is_sv && !full;
    assign wr_entry = '{x: wr_x, y: wr_y, alpha: wr_alpha};

    sv_entry_ram #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_ram (
        .clk   (clk),
        .we    (store),
        .waddr (count[AW-1:0]),
        .wdata (wr_entry),
        .raddr (idx[AW-1:0]),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (op == OP_CLEAR) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (store) begin
            count <= count + CNT_W'(1);
        end else if (wr_fire && wr_is_sv) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_x     <= '0;
            rd_y     <= '0;
            rd_alpha <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_start && op == OP_CLASSIFY && count != '0) begin
                        state <= ST_STREAM;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    // Any opcode other than CLASSIFY abandons the pass.
                    if (op != OP_CLASSIFY) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                    end else if (!rd_valid || rd_ready) begin
                        if (rd_valid && rd_last) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                        end else begin
                            rd_x     <= rd_entry.x;
                            rd_y     <= rd_entry.y;
                            rd_alpha <= rd_entry.alpha;
                            rd_valid <= 1'b1;
                            rd_last  <= (idx == count - CNT_W'(1));
                            idx      <= idx + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sv_store.sv
// Self-checking bench for sv_store: directed scenarios plus randomized
// train/classify rounds against a queue-based model of the stored entries.
`timescale 1ns/1ps
module tb_sv_store;
    import sv_pkg::*;

    localparam int X_W     = 9;
    localparam int ALPHA_W = 9;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         opcode;
    logic               wr_valid;
    logic               wr_ready;
    logic               wr_is_sv;
    logic [X_W-1:0]     wr_x;
    logic signed [1:0]  wr_y;
    logic [ALPHA_W-1:0] wr_alpha;
    logic               rd_start;
    logic               rd_valid;
    logic               rd_ready;
    logic [X_W-1:0]     rd_x;
    logic signed [1:0]  rd_y;
    logic [ALPHA_W-1:0] rd_alpha;
    logic               rd_last;
    logic               busy;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               overflow;

    sv_store #(.X_W(X_W), .ALPHA_W(ALPHA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_is_sv(wr_is_sv),
        .wr_x(wr_x), .wr_y(wr_y), .wr_alpha(wr_alpha),
        .rd_start(rd_start), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_x(rd_x), .rd_y(rd_y), .rd_alpha(rd_alpha), .rd_last(rd_last),
        .busy(busy), .count(count), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [X_W-1:0]     x;
        logic [1:0]         y;
        logic [ALPHA_W-1:0] alpha;
    } ent_t;

    ent_t store_q[$];
    bit   ovf_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status();
        check("count", 32'(count), 32'(store_q.size()));
        check("full", 32'(full), 32'(store_q.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(ovf_m));
    endtask

    // One handshake attempt under the given opcode; model updated from the rules.
    task automatic offer(input logic [X_W-1:0] x, input logic [1:0] y,
                         input logic [ALPHA_W-1:0] a, input bit sv, input logic [1:0] op);
        ent_t e;
        opcode = op; wr_valid = 1'b1; wr_x = x; wr_y = y; wr_alpha = a; wr_is_sv = sv;
        #1 check("wr_ready", 32'(wr_ready), 32'(op == OP_TRAIN));
        tick();
        wr_valid = 1'b0;
        if (op == OP_TRAIN && sv) begin
            if (store_q.size() < DEPTH) begin
                e.x = x; e.y = y; e.alpha = a;
                store_q.push_back(e);
            end else begin
                ovf_m = 1'b1;
            end
        end else if (op == OP_CLEAR) begin
            store_q.delete();
            ovf_m = 1'b0;
        end
        check_status();
    endtask

    task automatic offer_rand(input logic [1:0] op);
        logic [1:0] y;
        y = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11;
        offer(X_W'($urandom), y, ALPHA_W'($urandom), bit'($urandom_range(0, 1)), op);
    endtask

    // mode 0: ready held high; 1: ready pattern 1,0,0,...; 2: random ready.
    task automatic run_pass(input int mode);
        int n, k, cyc;
        bit rdy;
        n = store_q.size(); k = 0; cyc = 0;
        opcode = OP_CLASSIFY; rd_start = 1'b1; rd_ready = 1'b0;
        tick();
        rd_start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_valid", 32'(rd_valid), 32'd0);
        tick();
        check("latency_valid", 32'(rd_valid), 32'd1);
        while (k < n && cyc < 64) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = bit'($urandom_range(0, 1));
            endcase
            rd_ready = rdy;
            rd_start = (mode != 0 && cyc == 2);
            check("stream_valid", 32'(rd_valid), 32'd1);
            check("stream_busy", 32'(busy), 32'd1);
            if (rd_valid) begin
                check("beat_x", 32'(rd_x), 32'(store_q[k].x));
                check("beat_y", {30'd0, rd_y}, {30'd0, store_q[k].y});
                check("beat_alpha", 32'(rd_alpha), 32'(store_q[k].alpha));
                check("beat_last", 32'(rd_last), 32'(k == n - 1));
                if (rdy) k++;
            end
            tick();
            cyc++;
        end
        rd_start = 1'b0; rd_ready = 1'b0;
        check("pass_beats", 32'(k), 32'(n));
        check("end_valid", 32'(rd_valid), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; opcode = OP_TRAIN; wr_valid = 1'b0; wr_is_sv = 1'b0;
        wr_x = '0; wr_y = '0; wr_alpha = '0; rd_start = 1'b0; rd_ready = 1'b0;
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_last", 32'(rd_last), 32'd0);
        check("rst_x", 32'(rd_x), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        reset = 1'b0;
        tick();

        // Compaction: x=10..14 with is_sv 1,0,1,1,0 keeps 10,12,13.
        for (int i = 0; i < 5; i++) begin
            automatic bit sv = (i == 0 || i == 2 || i == 3);
            offer(X_W'(10 + i), (i % 2 == 0) ? 2'b01 : 2'b11, ALPHA_W'(100 + i), sv, OP_TRAIN);
        end
        run_pass(0);

        // Empty store: pass requests do nothing.
        offer('0, 2'b01, '0, 1'b1, OP_CLEAR);
        opcode = OP_CLASSIFY; rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("empty_valid", 32'(rd_valid), 32'd0);
        check("empty_busy", 32'(busy), 32'd0);
        tick();
        check("empty_valid2", 32'(rd_valid), 32'd0);
        check("empty_busy2", 32'(busy), 32'd0);

        // Fill past capacity, then stalled pass with an ignored mid-pass start.
        for (int i = 0; i < 6; i++)
            offer(X_W'(200 + i), (i % 2 == 0) ? 2'b11 : 2'b01, ALPHA_W'(300 + i), 1'b1, OP_TRAIN);
        run_pass(1);

        // Abort after the second beat, with a write attempted while still busy.
        opcode = OP_CLASSIFY; rd_start = 1'b1;
        tick();
        rd_start = 1'b0; rd_ready = 1'b1;
        tick();
        check("abort_beat0", 32'(rd_x), 32'(store_q[0].x));
        tick();
        check("abort_beat1", 32'(rd_x), 32'(store_q[1].x));
        opcode = OP_TRAIN; wr_valid = 1'b1; wr_is_sv = 1'b1; wr_x = 9'd77;
        #1 check("busy_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        wr_valid = 1'b0; rd_ready = 1'b0;
        check("abort_valid", 32'(rd_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check_status();
        run_pass(0);

        offer('0, 2'b01, '0, 1'b0, OP_CLEAR);

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 2) == 0) offer('0, 2'b01, '0, 1'b0, OP_CLEAR);
            repeat ($urandom_range(1, 7)) begin
                case ($urandom_range(0, 5))
                    0: offer_rand(OP_HOLD);
                    1: begin
                        opcode = OP_TRAIN; wr_valid = 1'b0;
                        tick();
                        check_status();
                    end
                    default: offer_rand(OP_TRAIN);
                endcase
            end
            if (store_q.size() > 0) run_pass(2);
        end

        // Asynchronous reset between edges during a pass.
        if (store_q.size() == 0) offer_rand(OP_TRAIN);
        if (store_q.size() == 0) offer(9'd5, 2'b01, 9'd6, 1'b1, OP_TRAIN);
        opcode = OP_CLASSIFY; rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        check("pre_reset_valid", 32'(rd_valid), 32'd1);
        #3 reset = 1'b1; opcode = OP_TRAIN;
        #1;
        check("async_valid", 32'(rd_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_count", 32'(count), 32'd0);
        check("async_wr_ready", 32'(wr_ready), 32'd0);
        check("async_x", 32'(rd_x), 32'd0);
        store_q.delete();
        ovf_m = 1'b0;
        #2 reset = 1'b0;
        tick();
        check_status();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
